// File: rtl/rv_fifo_pkg.sv
// Shared types and sizing helpers for the rv_fifo_level elastic buffer.
package rv_fifo_pkg;

  typedef enum logic [1:0] {
    LVL_HOLD,
    LVL_INC,
    LVL_DEC
  } lvl_op_e;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rv_fifo_level_if.sv
// Ready/valid stream bundle; the producer side uses master, the consumer side slave.
interface rv_fifo_level_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rv_fifo_mem.sv
// FIFO storage: synchronous write, synchronous read of a registered address (read-old on collision).
module rv_fifo_mem
  import rv_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 10,
  localparam int unsigned AW         = addr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv_fifo_level.sv
// Parametrised ready/valid FIFO with occupancy, almost-full/empty and sticky overflow flags.
// Optional peak-occupancy tracking is enabled by defining RV_FIFO_HIGH_WATER_EN.
module rv_fifo_level
  import rv_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 8,
  parameter  int unsigned DEPTH        = 10,
  parameter  int unsigned AFULL_LEVEL  = DEPTH - 2,
  parameter  int unsigned AEMPTY_LEVEL = 2,
  localparam int unsigned LW           = level_width(DEPTH)
) (
  input  logic             clock_port,
  input  logic             reset_port,
  input  logic             clear,
  rv_fifo_level_if.slave   input_port,
  rv_fifo_level_if.master  output_port,
  output logic [LW-1:0]    level,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic [LW-1:0]    high_water
);

  localparam int unsigned   AW       = addr_width(DEPTH);
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LEVEL);

  logic [AW-1:0]         push_addr_q, push_addr_d;
  logic [AW-1:0]         pop_addr_q, pop_addr_d;
  logic                  looped_q, looped_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  overflow_q, overflow_d;
  logic                  byp_sel_q, byp_sel_d;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  push, pop, push_wrap, pop_wrap, ptr_eq, flush;
  lvl_op_e               lvl_op;

  assign flush = reset_port | clear;

  always_comb begin
    push        = input_port.valid & ~full_q;
    pop         = ~empty_q & output_port.ready;
    push_wrap   = push && (push_addr_q == LAST);
    pop_wrap    = pop && (pop_addr_q == LAST);

    push_addr_d = push_addr_q;
    if (push) push_addr_d = push_wrap ? '0 : push_addr_q + AW'(1);
    pop_addr_d  = pop_addr_q;
    if (pop) pop_addr_d = pop_wrap ? '0 : pop_addr_q + AW'(1);

    // Equal pointers mean full after the writer lapped the reader, empty otherwise
    looped_d = looped_q;
    if (push_wrap && !pop_wrap)      looped_d = 1'b1;
    else if (pop_wrap && !push_wrap) looped_d = 1'b0;
    ptr_eq  = (push_addr_d == pop_addr_d);
    full_d  = ptr_eq & looped_d;
    empty_d = ptr_eq & ~looped_d;

    lvl_op = LVL_HOLD;
    if (push && !pop)      lvl_op = LVL_INC;
    else if (pop && !push) lvl_op = LVL_DEC;
    case (lvl_op)
      LVL_INC: level_d = level_q + LW'(1);
      LVL_DEC: level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    afull_d    = (level_d >= AFULL_L);
    aempty_d   = (level_d <= AEMPTY_L);
    overflow_d = overflow_q | (input_port.valid & full_q);

    // Memory reads the old word when the head slot is written on the same edge
    byp_sel_d  = push && (pop_addr_d == push_addr_q);
  end

  always_ff @(posedge clock_port) begin
    if (flush) begin
      push_addr_q <= '0;
      pop_addr_q  <= '0;
      looped_q    <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      level_q     <= '0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      byp_sel_q   <= 1'b0;
    end else begin
      push_addr_q <= push_addr_d;
      pop_addr_q  <= pop_addr_d;
      looped_q    <= looped_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      level_q     <= level_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      byp_sel_q   <= byp_sel_d;
    end
  end

  always_ff @(posedge clock_port) begin
    if (push) byp_data_q <= input_port.data;
  end

  rv_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clock_port),
    .we_i    (push & ~flush),
    .waddr_i (push_addr_q),
    .wdata_i (input_port.data),
    .raddr_i (flush ? '0 : pop_addr_d),
    .rdata_o (mem_rdata)
  );

  assign input_port.ready   = ~full_q;
  assign output_port.valid  = ~empty_q;
  assign output_port.data   = byp_sel_q ? byp_data_q : mem_rdata;
  assign level              = level_q;
  assign almost_full        = afull_q;
  assign almost_empty       = aempty_q;
  assign overflow           = overflow_q;

`ifdef RV_FIFO_HIGH_WATER_EN
  logic [LW-1:0] hw_q, hw_d;

  always_comb begin
    hw_d = (level_d > hw_q) ? level_d : hw_q;
  end

  always_ff @(posedge clock_port) begin
    if (flush) hw_q <= '0;
    else       hw_q <= hw_d;
  end

  assign high_water = hw_q;
`else
  assign high_water = '0;
`endif

endmodule

// File: tb/tb_rv_fifo_level.sv
// Directed-vector bench for rv_fifo_level (DEPTH=10, DATA_WIDTH=8, default flag levels).
module tb_rv_fifo_level;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned LW    = 4;
`ifdef RV_FIFO_HIGH_WATER_EN
  localparam bit HW_EN = 1'b1;
`else
  localparam bit HW_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [LW-1:0] level;
  logic [LW-1:0] hw;
  logic          afull, aempty, ovf;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  rv_fifo_level_if #(.DATA_WIDTH(DW)) in_if ();
  rv_fifo_level_if #(.DATA_WIDTH(DW)) out_if ();

  rv_fifo_level #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock_port   (clk),
    .reset_port   (rst),
    .clear        (clr),
    .input_port   (in_if),
    .output_port  (out_if),
    .level        (level),
    .almost_full  (afull),
    .almost_empty (aempty),
    .overflow     (ovf),
    .high_water   (hw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    clr          = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(out_if.valid), 0);
    check("rst_ready", 32'(in_if.ready), 1);
    check("rst_aempty", 32'(aempty), 1);
    check("rst_afull", 32'(afull), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_hw", 32'(hw), 0);

    // fill to full with consumer stalled; head must stay 0x01
    for (int i = 1; i <= 10; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = 8'(i);
      tick();
      check("fill_level", 32'(level), 32'(i));
      check("fill_afull", 32'(afull), (i >= 8) ? 1 : 0);
      check("fill_aempty", 32'(aempty), (i <= 2) ? 1 : 0);
      check("fill_ready", 32'(in_if.ready), (i < 10) ? 1 : 0);
      check("fill_head", 32'(out_if.data), 32'h01);
    end
    check("fill_hw", 32'(hw), HW_EN ? 10 : 0);

    in_if.data = 8'hEE;
    tick();
    check("ovf_set", 32'(ovf), 1);
    check("ovf_level", 32'(level), 10);
    check("ovf_head", 32'(out_if.data), 32'h01);
    in_if.valid = 1'b0;

    out_if.ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      check("drain_valid", 32'(out_if.valid), 1);
      check("drain_data", 32'(out_if.data), 32'(i));
      tick();
      check("drain_level", 32'(level), 32'(10 - i));
    end
    check("drain_empty", 32'(out_if.valid), 0);
    check("drain_aempty", 32'(aempty), 1);
    check("drain_afull", 32'(afull), 0);
    check("ovf_sticky", 32'(ovf), 1);

    in_if.valid = 1'b1;
    in_if.data  = 8'h5A;
    tick();
    in_if.valid = 1'b0;
    check("byp_valid", 32'(out_if.valid), 1);
    check("byp_data", 32'(out_if.data), 32'h5A);
    check("byp_level", 32'(level), 1);
    tick();
    check("byp_popped", 32'(out_if.valid), 0);
    check("byp_level0", 32'(level), 0);

    // stream 25 values at constant occupancy 3, crossing both pointer wraps
    out_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_if.valid = 1'b1;
      in_if.data  = 8'(8'h10 + k);
      tick();
    end
    check("strm_prime", 32'(level), 3);
    out_if.ready = 1'b1;
    for (int k = 3; k < 25; k++) begin
      in_if.data = 8'(8'h10 + k);
      check("strm_data", 32'(out_if.data), 32'(8'h10 + k - 3));
      tick();
      check("strm_level", 32'(level), 3);
    end
    in_if.valid = 1'b0;
    for (int k = 22; k < 25; k++) begin
      check("strm_tail", 32'(out_if.data), 32'(8'h10 + k));
      tick();
      check("strm_tail_lvl", 32'(level), 32'(24 - k));
    end

    out_if.ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_if.valid = 1'b1;
      in_if.data  = 8'(8'h40 + k);
      tick();
    end
    check("clr_pre_level", 32'(level), 6);
    clr        = 1'b1;
    in_if.data = 8'h77;
    tick();
    clr         = 1'b0;
    in_if.valid = 1'b0;
    check("clr_level", 32'(level), 0);
    check("clr_valid", 32'(out_if.valid), 0);
    check("clr_ovf", 32'(ovf), 0);
    check("clr_ready", 32'(in_if.ready), 1);
    check("clr_aempty", 32'(aempty), 1);
    check("clr_hw", 32'(hw), 0);
    tick();
    check("clr_discard", 32'(out_if.valid), 0);
    in_if.valid = 1'b1;
    in_if.data  = 8'h33;
    tick();
    in_if.valid = 1'b0;
    check("clr_new_data", 32'(out_if.data), 32'h33);
    out_if.ready = 1'b1;
    tick();
    check("clr_new_pop", 32'(level), 0);

    out_if.ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_if.valid = 1'b1;
      in_if.data  = 8'(8'h60 + k);
      tick();
    end
    in_if.valid = 1'b0;
    check("hw_fill_level", 32'(level), 7);
    check("hw_fill", 32'(hw), HW_EN ? 7 : 0);
    out_if.ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    out_if.ready = 1'b0;
    check("hw_drain_level", 32'(level), 2);
    check("hw_drain", 32'(hw), HW_EN ? 7 : 0);
    check("hw_head", 32'(out_if.data), 32'h65);
    check("hw_aempty", 32'(aempty), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("hw_clr", 32'(hw), 0);
    check("hw_clr_level", 32'(level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rv_fifo_level.md
Name: rv_fifo_level

Overview:
- Parametrised ready/valid FIFO; next generation of the team's fixed 8-bit, 10-entry buffer FIFO.
- Generalised in data width and depth, including non-power-of-2 depths.
- Adds an occupancy count, programmable almost-full/almost-empty flags, and a sticky overflow-attempt flag.
- Sits between streaming producer/consumer stages anywhere in the design; it is the default elastic buffer for new blocks.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- DEPTH, 10, number of entries; must be at least 2; need not be a power of 2.
- AFULL_LEVEL, DEPTH-2, almost_full asserts when level >= AFULL_LEVEL.
- AEMPTY_LEVEL, 2, almost_empty asserts when level <= AEMPTY_LEVEL.

Ports:
- clock_port  in  1  single clock; everything is on its rising edge.
- reset_port  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; same effect as reset on FIFO state.
- input_port_data  in  DATA_WIDTH  write payload.
- input_port_valid  in  1  producer has data.
- input_port_ready  out  1  FIFO can accept data.
- output_port_data  out  DATA_WIDTH  head-of-queue payload.
- output_port_valid  out  1  head is valid.
- output_port_ready  in  1  consumer accepts the head.
- level  out  LW  current occupancy; LW = clog2(DEPTH+1).
- almost_full  out  1  level >= AFULL_LEVEL.
- almost_empty  out  1  level <= AEMPTY_LEVEL.
- overflow  out  1  sticky: a push was attempted while full.
- high_water  out  LW  peak occupancy since the last reset/clear (see Optional Feature).

Behaviour:
- Reset/clear values:
  - push_addr=0, pop_addr=0, level=0, overflow=0, high_water=0.
  - output_port_valid=0, input_port_ready=1, almost_empty=1, almost_full=0.
- Reset has priority over clear. Either one, asserted mid-stream, discards all contents on the next edge.
- Transfer rules:
  - push = input_port_valid & input_port_ready.
  - pop = output_port_valid & output_port_ready.
  - input_port_ready = ~full and does not depend on output_port_ready, so there is no combinational ready path.
  - output_port_valid = ~empty.
- Pointer wrap: each pointer counts 0..DEPTH-1 and then wraps to 0. Full and empty are distinguished by a looped bit:
  - set when push wraps alone;
  - cleared when pop wraps alone;
  - unchanged when both or neither wrap.
- full, empty and looped are registered, computed from the next-state pointers.
- Level update:
  - level +1 on push only;
  - level -1 on pop only;
  - unchanged on simultaneous push and pop, or on neither.
- The level never exceeds DEPTH and never goes below 0. almost_full and almost_empty are registered, derived from the next level.
- Simultaneous push and pop:
  - when full: pop frees a slot, but push is blocked because ready was low that cycle;
  - when empty: push only, since valid was low.
- Memory: synchronous write at push_addr. The read address is registered as next_pop_addr, so data is valid one cycle after the address settles.
- Write-to-read bypass:
  - if the previous cycle pushed to push_addr_prev and next_pop_addr equals that address, output_port_data comes from a register holding the previous cycle's input_port_data;
  - otherwise it comes from memory.
- Latency: a push into an empty FIFO at edge N gives output_port_valid=1 with correct data after edge N; one-cycle latency.
- Data holding: output_port_data is stable while output_port_valid=1 and output_port_ready=0.
- Overflow flag: set when input_port_valid=1 while full. It stays set until reset or clear. It does not affect data flow.
- Memory contents are not reset.

Optional Feature:
- Macro: RV_FIFO_HIGH_WATER_EN.
- Defined: high_water is a register updated to max(high_water, next level) every cycle, and cleared by reset or clear.
- Undefined: high_water is tied to 0 and no register is inferred.

Decomposition:
- Package rv_fifo_pkg holds:
  - function level_width(depth), returning clog2(depth+1);
  - function addr_width(depth), returning max(1, clog2(depth)).
- Sub-module rv_fifo_mem: dual-port memory with a synchronous write port and a registered read address (DATA_WIDTH x DEPTH). All pointer and flag logic stays in rv_fifo_level.

Test Plan:
- Fill to full: DEPTH=10, consumer stalled, push 0x01..0x0A → after 10 pushes input_port_ready=0, level=10, almost_full=1 from level 8. An 11th valid sets overflow=1 and level stays 10.
- Drain in order: from full, set output_port_ready=1 → outputs 0x01..0x0A in order, one per cycle. Then output_port_valid=0, level=0, almost_empty=1.
- Bypass at empty: push 0x5A at edge N, consumer ready → output_port_valid=1 and output_port_data=0x5A after edge N; popped at edge N+1; level back to 0.
- Wrap with simultaneous push/pop: keep occupancy at 3 while streaming 25 values → every value arrives in order across both pointer wraps, and level stays 3 throughout.
- Clear mid-stream: level=6, assert clear for one cycle with input_port_valid=1 → next cycle level=0, output_port_valid=0, overflow=0, and the pushed word is discarded.
- High water, with the macro defined: fill to 7 and drain to 2 → high_water=7. After clear, high_water=0. With the macro undefined, high_water is always 0.
